// File: rtl/programmable_clock_divider.sv
// Multi-channel programmable divider: per-channel square wave and last-cycle tick, outputs registered (1-cycle state-to-output).
// Divisor loads use valid/ready; a channel stalls further loads until its shadow divisor is applied at a period boundary.
module programmable_clock_divider #(
    parameter int WIDTH       = 28,
    parameter int NUM_CH      = 2,
    parameter int DEFAULT_DIV = 4,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock_in,
    input  logic              reset,
    input  logic              enable,
    input  logic              restart,
    input  logic              load_valid,
    input  logic [CH_W-1:0]   load_ch,
    input  logic [WIDTH-1:0]  load_div,
    output logic              load_ready,
    output logic [NUM_CH-1:0] clock_out,
    output logic [NUM_CH-1:0] tick_out
);

    logic [WIDTH-1:0]  cnt       [NUM_CH];
    logic [WIDTH-1:0]  div_act   [NUM_CH];
    logic [WIDTH-1:0]  div_shd   [NUM_CH];
    logic [NUM_CH-1:0] pending;

    logic [WIDTH-1:0]  cnt_n     [NUM_CH];
    logic [WIDTH-1:0]  div_act_n [NUM_CH];
    logic [WIDTH-1:0]  div_shd_n [NUM_CH];
    logic [NUM_CH-1:0] pending_n;
    logic [NUM_CH-1:0] clock_n;
    logic [NUM_CH-1:0] tick_n;
    logic [WIDTH-1:0]  div_clamp;

    // An out-of-range channel never matches any index, so it is never ready.
    always_comb begin
        load_ready = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (load_ch == CH_W'(i) && !pending[i]) begin
                load_ready = 1'b1;
            end
        end
    end

    assign div_clamp = (load_div < WIDTH'(2)) ? WIDTH'(2) : load_div;

    always_comb begin
        clock_n   = '0;
        tick_n    = '0;
        pending_n = pending;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_n[i]     = cnt[i];
            div_act_n[i] = div_act[i];
            div_shd_n[i] = div_shd[i];
            if (restart) begin
                cnt_n[i] = '0;
                if (pending[i]) begin
                    div_act_n[i] = div_shd[i];
                    pending_n[i] = 1'b0;
                end
            end else if (enable) begin
                if (cnt[i] == div_act[i] - WIDTH'(1)) begin
                    cnt_n[i] = '0;
                    if (pending[i]) begin
                        div_act_n[i] = div_shd[i];
                        pending_n[i] = 1'b0;
                    end
                end else begin
                    cnt_n[i] = cnt[i] + WIDTH'(1);
                end
            end
            // Accept only happens with pending low, so a same-cycle wrap or restart never applies it.
            if (load_valid && load_ready && load_ch == CH_W'(i)) begin
                div_shd_n[i] = div_clamp;
                pending_n[i] = 1'b1;
            end
            clock_n[i] = (cnt_n[i] >= (div_act_n[i] >> 1));
            tick_n[i]  = (cnt_n[i] == div_act_n[i] - WIDTH'(1));
        end
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]     <= '0;
                div_act[i] <= WIDTH'(DEFAULT_DIV);
                div_shd[i] <= WIDTH'(DEFAULT_DIV);
            end
            pending   <= '0;
            clock_out <= '0;
            tick_out  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]     <= cnt_n[i];
                div_act[i] <= div_act_n[i];
                div_shd[i] <= div_shd_n[i];
            end
            pending   <= pending_n;
            clock_out <= clock_n;
            tick_out  <= tick_n;
        end
    end

endmodule

// File: tb/tb_programmable_clock_divider.sv
// Directed bench for programmable_clock_divider with three channels so an out-of-range channel select exists.
module tb_programmable_clock_divider;

    localparam int W  = 28;
    localparam int N  = 3;
    localparam int CW = 2;

    logic          clock_in = 1'b0;
    logic          reset    = 1'b1;
    logic          enable   = 1'b0;
    logic          restart  = 1'b0;
    logic          load_valid = 1'b0;
    logic [CW-1:0] load_ch  = '0;
    logic [W-1:0]  load_div = '0;
    logic          load_ready;
    logic [N-1:0]  clock_out;
    logic [N-1:0]  tick_out;

    int checks = 0;
    int errors = 0;

    programmable_clock_divider #(
        .WIDTH(W), .NUM_CH(N), .DEFAULT_DIV(4), .CH_W(CW)
    ) dut (
        .clock_in(clock_in), .reset(reset), .enable(enable), .restart(restart),
        .load_valid(load_valid), .load_ch(load_ch), .load_div(load_div),
        .load_ready(load_ready), .clock_out(clock_out), .tick_out(tick_out)
    );

    always #5 clock_in = ~clock_in;

    task automatic tk();
        @(posedge clock_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        tk(); tk();
        chk("reset_clk", 32'(clock_out), 0);
        chk("reset_tick", 32'(tick_out), 0);
        chk("reset_ready", 32'(load_ready), 1);
        reset  = 1'b0;
        enable = 1'b1;
        chk("release_clk", 32'(clock_out), 0);

        // Default divisor 4: all channels 0,0,1,1 with tick at cnt 3
        for (int k = 1; k <= 8; k++) begin
            tk();
            chk("def_clk", 32'(clock_out), 32'({3{(k % 4) >= 2}}));
            chk("def_tick", 32'(tick_out), 32'({3{(k % 4) == 3}}));
        end

        // Load ch1 div 5 while ch1 is at cnt 1
        tk();
        load_valid = 1'b1; load_ch = 2'd1; load_div = 28'd5;
        chk("ld5_ready", 32'(load_ready), 1);
        tk();
        load_valid = 1'b0;
        chk("ld5_stall", 32'(load_ready), 0);
        chk("ld5_clk_c2", 32'(clock_out[1:0]), 32'h3);
        tk();
        chk("ld5_tick_c3", 32'(tick_out[1:0]), 32'h3);
        chk("ld5_stall2", 32'(load_ready), 0);
        tk();
        chk("ld5_wrap_clk", 32'(clock_out[1:0]), 0);
        chk("ld5_ready_back", 32'(load_ready), 1);
        for (int k = 1; k <= 20; k++) begin
            tk();
            chk("div5_clk", 32'(clock_out[1:0]), 32'({(k % 5) >= 2, (k % 4) >= 2}));
            chk("div5_tick", 32'(tick_out[1:0]), 32'({(k % 5) == 4, (k % 4) == 3}));
        end

        // Load ch0 div 1 then div 0; both clamp to 2
        load_valid = 1'b1; load_ch = 2'd0; load_div = 28'd1;
        chk("ld1_ready", 32'(load_ready), 1);
        tk();
        load_div = 28'd0;
        chk("ld0_stall_a", 32'(load_ready), 0);
        tk();
        chk("ld0_stall_b", 32'(load_ready), 0);
        tk();
        chk("ld0_stall_c", 32'(load_ready), 0);
        tk();
        chk("ld0_ready", 32'(load_ready), 1);
        tk();
        load_valid = 1'b0;
        chk("ld0_pending", 32'(load_ready), 0);
        chk("div2_clk_a", 32'(clock_out[0]), 1);
        chk("div2_tick_a", 32'(tick_out[0]), 1);
        tk();
        chk("ld0_applied", 32'(load_ready), 1);
        for (int k = 1; k <= 10; k++) begin
            tk();
            chk("div2_clk", 32'(clock_out[1:0]), 32'({((1 + k) % 5) >= 2, (k % 2) == 1}));
            chk("div2_tick", 32'(tick_out[1:0]), 32'({((1 + k) % 5) == 4, (k % 2) == 1}));
        end

        // Back to div 4 on ch0, then freeze at cnt 2
        load_valid = 1'b1; load_ch = 2'd0; load_div = 28'd4;
        tk();
        load_valid = 1'b0;
        tk(); tk(); tk();
        chk("pre_freeze_clk", 32'(clock_out[1:0]), 32'h1);
        chk("pre_freeze_tick", 32'(tick_out[1:0]), 0);
        enable = 1'b0;
        load_valid = 1'b1; load_ch = 2'd1; load_div = 28'd6;
        chk("freeze_ld_ready", 32'(load_ready), 1);
        for (int k = 1; k <= 7; k++) begin
            tk();
            load_valid = 1'b0;
            chk("freeze_clk", 32'(clock_out[1:0]), 32'h1);
            chk("freeze_tick", 32'(tick_out[1:0]), 0);
        end
        chk("freeze_ld_pending", 32'(load_ready), 0);
        enable = 1'b1;
        tk();
        chk("resume_clk", 32'(clock_out[1:0]), 32'h1);
        chk("resume_tick", 32'(tick_out[1:0]), 32'h1);

        // Restart with pending div 6 on ch1; out-of-range load in the same cycle
        load_valid = 1'b1; load_ch = 2'd3; load_div = 28'd9;
        chk("oor_ready", 32'(load_ready), 0);
        restart = 1'b1;
        tk();
        restart = 1'b0;
        chk("oor_ready_b", 32'(load_ready), 0);
        load_valid = 1'b0;
        chk("restart_clk", 32'(clock_out), 0);
        chk("restart_tick", 32'(tick_out), 0);
        for (int k = 1; k <= 12; k++) begin
            tk();
            chk("div6_clk", 32'(clock_out), 32'({(k % 4) >= 2, (k % 6) >= 3, (k % 4) >= 2}));
            chk("div6_tick", 32'(tick_out), 32'({(k % 4) == 3, (k % 6) == 5, (k % 4) == 3}));
        end

        // Asynchronous reset mid-high phase of ch1
        tk(); tk(); tk(); tk();
        chk("pre_rst_clk1", 32'(clock_out[1]), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_clk", 32'(clock_out), 0);
        chk("async_rst_tick", 32'(tick_out), 0);
        tk();
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tk();
            chk("post_rst_clk", 32'(clock_out), 32'({3{(k % 4) >= 2}}));
            chk("post_rst_tick", 32'(tick_out), 32'({3{(k % 4) == 3}}));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
